regmap_access_arbiter: RTL
==========================

REGMAP_ACCESS_ARBITER -- requirements
Module: regmap_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, regmap address width.
REQ-002 SHALL have parameter DATA_W, default 8, regmap data width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, request-toggle synchronizer depth (min 2).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port button_0  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports i2c_req_tgl / spi_req_tgl  input  1  request toggle from the I2C / SPI slave engine (foreign domain).
REQ-007 SHALL have ports i2c_we / spi_we  input  1  1=write, 0=read; stable from toggle until ack.
REQ-008 SHALL have ports i2c_addr / spi_addr  input  ADDR_W  target address; stable from toggle until ack.
REQ-009 SHALL have ports i2c_wdata / spi_wdata  input  DATA_W  write data; stable from toggle until ack.
REQ-010 SHALL have ports i2c_ack_tgl / spi_ack_tgl  output  1  completion toggle back to the requester.
REQ-011 SHALL have ports i2c_rdata / spi_rdata  output  DATA_W  read data; valid when ack toggles.
REQ-012 SHALL have ports i2c_ovr / spi_ovr  output  1  sticky overrun flag.
REQ-013 SHALL have port rm_addr  output  ADDR_W; port rm_wdata  output  DATA_W.
REQ-014 SHALL have ports rm_we / rm_re  output  1  single-cycle write / read strobes to the regmap.
REQ-015 SHALL have port rm_rdata  input  DATA_W  regmap read data, valid the cycle after rm_re.

Function
REQ-016 SHALL pass each req_tgl through SYNC_STAGES flops; an event is the last two stages differing.
REQ-017 SHALL, on an event, capture we/addr/wdata into that port's pending slot and set pending at the same edge.
REQ-018 SHALL use FSM states IDLE, ISSUE, CAPTURE.
REQ-019 IDLE: if any pending, latch the granted port and its slot, go ISSUE next edge; else stay.
REQ-020 Tie (both pending in IDLE): SHALL grant the port not granted last; last_grant resets to SPI, so first tie goes to I2C.
REQ-021 ISSUE (one cycle): SHALL drive rm_addr/rm_wdata from the granted slot; rm_we=1 for write or rm_re=1 for read.
REQ-022 ISSUE exit, write: SHALL flip the granted ack_tgl, clear its pending, and return to IDLE.
REQ-023 ISSUE exit, read: SHALL go to CAPTURE.
REQ-024 CAPTURE exit: SHALL latch rm_rdata into the granted rdata, flip ack_tgl, clear pending, and return to IDLE.
REQ-025 Latency from pending-set edge to ack flip SHALL be 2 edges for write and 3 edges for read, uncontended.
REQ-026 rm_we and rm_re SHALL never both be high, and each SHALL be high for at most one cycle per grant.
REQ-027 An event on a port whose pending is set and not cleared that edge SHALL be dropped and SHALL set that port's ovr.
REQ-028 An event coinciding with the edge that clears the same port's pending SHALL be captured as a new request, with no overrun.
REQ-029 The non-granted port's rdata and ack_tgl SHALL hold their values.
REQ-030 Addresses SHALL pass through unchecked; decode is the regmap's job.

Reset
REQ-031 button_0 high SHALL asynchronously clear synchronizers, pending, ovr, ack_tgl, rdata (0), FSM (IDLE), last_grant (SPI), and rm_* strobes/buses (0).
REQ-032 Reset mid-access SHALL abort without any further rm strobe; requesters SHALL reset their req_tgl to 0 with the same reset.

Verification
REQ-033 Single SPI write addr 0x02 data 0x92 -> one rm_we cycle with rm_addr=0x02, rm_wdata=0x92; spi_ack_tgl flips 2 edges after pending set.
REQ-034 SPI read addr 0x01 with regmap returning 0x24 -> one rm_re cycle; spi_rdata=0x24 when spi_ack_tgl flips 3 edges after pending set.
REQ-035 I2C write 0x02<-0x3A and SPI write 0x00<-0xE5 toggled same cycle after reset -> I2C served first, then SPI; the next tie goes to I2C again (last_grant=SPI).
REQ-036 Second spi_req_tgl flip while the first SPI request is pending behind an I2C access -> second request dropped; spi_ovr=1 until reset.
REQ-037 button_0 asserted during ISSUE of a read -> no CAPTURE, ack_tgl/rdata/ovr=0, FSM IDLE, and no rm strobe until a new event.

Source files
------------

// File: rtl/regmap_access_arbiter.sv
// Arbitrates regmap accesses from I2C and SPI slave engines running in foreign clock domains.
// Toggle handshakes in both directions; one access in flight, alternating grant on ties.
module regmap_access_arbiter #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              button_0,
    input  logic              i2c_req_tgl,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_ack_tgl,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_ovr,
    input  logic              spi_req_tgl,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_ack_tgl,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_ovr,
    output logic [ADDR_W-1:0] rm_addr,
    output logic [DATA_W-1:0] rm_wdata,
    output logic              rm_we,
    output logic              rm_re,
    input  logic [DATA_W-1:0] rm_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_i2c_sync;
    logic [SYNC_STAGES-1:0] r_spi_sync;

    logic              r_i2c_pend, r_i2c_we, r_i2c_ovr, r_i2c_ack;
    logic [ADDR_W-1:0] r_i2c_addr;
    logic [DATA_W-1:0] r_i2c_wdata, r_i2c_rdata;
    logic              r_spi_pend, r_spi_we, r_spi_ovr, r_spi_ack;
    logic [ADDR_W-1:0] r_spi_addr;
    logic [DATA_W-1:0] r_spi_wdata, r_spi_rdata;

    logic              r_gnt_spi, r_last_spi, r_rd;
    logic              r_rm_we, r_rm_re;
    logic [ADDR_W-1:0] r_rm_addr;
    logic [DATA_W-1:0] r_rm_wdata;

    logic w_i2c_evt, w_spi_evt;
    logic w_done, w_i2c_done, w_spi_done;
    logic w_pick_spi, w_pick_we;

    assign w_i2c_evt = r_i2c_sync[SYNC_STAGES-1] ^ r_i2c_sync[SYNC_STAGES-2];
    assign w_spi_evt = r_spi_sync[SYNC_STAGES-1] ^ r_spi_sync[SYNC_STAGES-2];

    // An access completes at ISSUE exit for writes and at CAPTURE exit for reads.
    assign w_done     = ((r_state == ISSUE) && !r_rd) || (r_state == CAPTURE);
    assign w_i2c_done = w_done && !r_gnt_spi;
    assign w_spi_done = w_done && r_gnt_spi;

    assign w_pick_spi = r_spi_pend && (!r_i2c_pend || !r_last_spi);
    assign w_pick_we  = w_pick_spi ? r_spi_we : r_i2c_we;

    always_ff @(posedge clk or posedge button_0) begin
        if (button_0) begin
            r_i2c_sync  <= '0;
            r_spi_sync  <= '0;
            r_i2c_pend  <= 1'b0;
            r_i2c_we    <= 1'b0;
            r_i2c_addr  <= '0;
            r_i2c_wdata <= '0;
            r_i2c_ovr   <= 1'b0;
            r_spi_pend  <= 1'b0;
            r_spi_we    <= 1'b0;
            r_spi_addr  <= '0;
            r_spi_wdata <= '0;
            r_spi_ovr   <= 1'b0;
        end else begin
            r_i2c_sync <= {r_i2c_sync[SYNC_STAGES-2:0], i2c_req_tgl};
            r_spi_sync <= {r_spi_sync[SYNC_STAGES-2:0], spi_req_tgl};

            // A slot freed on this very edge may accept the new request.
            if (w_i2c_evt) begin
                if (!r_i2c_pend || w_i2c_done) begin
                    r_i2c_pend  <= 1'b1;
                    r_i2c_we    <= i2c_we;
                    r_i2c_addr  <= i2c_addr;
                    r_i2c_wdata <= i2c_wdata;
                end else begin
                    r_i2c_ovr <= 1'b1;
                end
            end else if (w_i2c_done) begin
                r_i2c_pend <= 1'b0;
            end

            if (w_spi_evt) begin
                if (!r_spi_pend || w_spi_done) begin
                    r_spi_pend  <= 1'b1;
                    r_spi_we    <= spi_we;
                    r_spi_addr  <= spi_addr;
                    r_spi_wdata <= spi_wdata;
                end else begin
                    r_spi_ovr <= 1'b1;
                end
            end else if (w_spi_done) begin
                r_spi_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge button_0) begin
        if (button_0) begin
            r_state     <= IDLE;
            r_gnt_spi   <= 1'b0;
            r_last_spi  <= 1'b1;
            r_rd        <= 1'b0;
            r_rm_we     <= 1'b0;
            r_rm_re     <= 1'b0;
            r_rm_addr   <= '0;
            r_rm_wdata  <= '0;
            r_i2c_ack   <= 1'b0;
            r_spi_ack   <= 1'b0;
            r_i2c_rdata <= '0;
            r_spi_rdata <= '0;
        end else begin
            r_rm_we <= 1'b0;
            r_rm_re <= 1'b0;
            if (w_i2c_done) r_i2c_ack <= ~r_i2c_ack;
            if (w_spi_done) r_spi_ack <= ~r_spi_ack;
            case (r_state)
                IDLE: begin
                    if (r_i2c_pend || r_spi_pend) begin
                        r_gnt_spi  <= w_pick_spi;
                        r_last_spi <= w_pick_spi;
                        r_rd       <= !w_pick_we;
                        r_rm_we    <= w_pick_we;
                        r_rm_re    <= !w_pick_we;
                        r_rm_addr  <= w_pick_spi ? r_spi_addr : r_i2c_addr;
                        r_rm_wdata <= w_pick_spi ? r_spi_wdata : r_i2c_wdata;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= r_rd ? CAPTURE : IDLE;
                end
                CAPTURE: begin
                    if (r_gnt_spi) r_spi_rdata <= rm_rdata;
                    else           r_i2c_rdata <= rm_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i2c_ack_tgl = r_i2c_ack;
    assign i2c_rdata   = r_i2c_rdata;
    assign i2c_ovr     = r_i2c_ovr;
    assign spi_ack_tgl = r_spi_ack;
    assign spi_rdata   = r_spi_rdata;
    assign spi_ovr     = r_spi_ovr;
    assign rm_addr     = r_rm_addr;
    assign rm_wdata    = r_rm_wdata;
    assign rm_we       = r_rm_we;
    assign rm_re       = r_rm_re;

endmodule
